// File: rtl/wired_bus_arbiter_if.sv
// Shared-net arbitration bundle: level requests in, one-hot drive enables and status out.
// The arbiter takes the master view; requesters (or a bench) take the slave view.
interface wired_bus_arbiter_if #(
    parameter int NREQ = 4
);
    localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0] req;
    logic [NREQ-1:0] grant;
    logic [OW-1:0]   owner;
    logic            busy;
    logic            timeout;

    modport master (
        input  req,
        output grant,
        output owner,
        output busy,
        output timeout
    );

    modport slave (
        output req,
        input  grant,
        input  owner,
        input  busy,
        input  timeout
    );
endinterface

// File: rtl/wired_bus_arbiter.sv
// Round-robin owner arbiter for a shared wired-OR/AND net: one-hot drive enable,
// bounded tenure, and forced all-zero turnaround so two drivers never overlap.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// IDLE       | bus undriven, arbitrating among req (round-robin from last+1)
// OWN        | grant[owner] asserted, hold_cnt counting owned cycles
// TURNAROUND | grant all-zero for TURN cycles, requests ignored
module wired_bus_arbiter #(
    parameter int NREQ     = 4,
    parameter int MAX_HOLD = 8,
    parameter int TURN     = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    wired_bus_arbiter_if.master    bus
);
    localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [7:0]    HOLD_LAST = 8'(MAX_HOLD - 1);
    localparam logic [2:0]    TURN_LAST = 3'(TURN - 1);
    localparam logic [OW-1:0] LAST_RST  = OW'(NREQ - 1);
    localparam logic [NREQ-1:0] ONE     = {{(NREQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        OWN        = 2'd1,
        TURNAROUND = 2'd2
    } state_t;

    state_t          state;
    logic [NREQ-1:0] grant;
    logic [OW-1:0]   owner;
    logic [OW-1:0]   last;
    logic            busy;
    logic            timeout;
    logic [7:0]      hold_cnt;
    logic [2:0]      turn_cnt;

    logic [NREQ-1:0] hi_req;
    logic [OW-1:0]   sel_hi;
    logic [OW-1:0]   sel_lo;
    logic [OW-1:0]   sel;
    logic            owner_req;

    // Round-robin pick: lowest requester above last, else wrap to lowest overall.
    always_comb begin
        hi_req = '0;
        sel_hi = '0;
        sel_lo = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (bus.req[i] && (OW'(i) > last)) begin
                hi_req[i] = 1'b1;
            end
        end
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (hi_req[i]) begin
                sel_hi = OW'(i);
            end
            if (bus.req[i]) begin
                sel_lo = OW'(i);
            end
        end
        sel = (hi_req != '0) ? sel_hi : sel_lo;
    end

    assign owner_req = bus.req[owner];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            grant    <= '0;
            owner    <= '0;
            last     <= LAST_RST;
            busy     <= 1'b0;
            timeout  <= 1'b0;
            hold_cnt <= '0;
            turn_cnt <= '0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req != '0) begin
                        state    <= OWN;
                        grant    <= ONE << sel;
                        owner    <= sel;
                        busy     <= 1'b1;
                        hold_cnt <= '0;
                    end
                end
                OWN: begin
                    // A drop on the limit cycle counts as a normal release.
                    if (!owner_req || (hold_cnt == HOLD_LAST)) begin
                        state    <= TURNAROUND;
                        grant    <= '0;
                        busy     <= 1'b0;
                        last     <= owner;
                        turn_cnt <= '0;
                        timeout  <= owner_req;
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                TURNAROUND: begin
                    if (turn_cnt == TURN_LAST) begin
                        state <= IDLE;
                    end else begin
                        turn_cnt <= turn_cnt + 3'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.grant   = grant;
    assign bus.owner   = owner;
    assign bus.busy    = busy;
    assign bus.timeout = timeout;
endmodule

// File: tb/tb_wired_bus_arbiter.sv
// Directed bench for wired_bus_arbiter: stimulus queues expected tenures, a negedge
// monitor reconstructs each tenure from grant and checks it plus per-cycle invariants.
module tb_wired_bus_arbiter;
    logic clk;
    logic rst_n;

    wired_bus_arbiter_if #(.NREQ(4)) bus ();

    wired_bus_arbiter #(.NREQ(4), .MAX_HOLD(8), .TURN(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] grant;
        logic [1:0] owner;
        int         len;
        logic       tmo;
        int         gap;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
        checks++;
        if (act !== req_v) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req_v, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] g, input logic [1:0] o, input int len,
                        input logic tmo, input int gap);
        exp_t e;
        e.grant = g; e.owner = o; e.len = len; e.tmo = tmo; e.gap = gap;
        q.push_back(e);
    endtask

    // Monitor state
    logic [3:0] prev_g     = '0;
    logic       prev_busy  = 1'b0;
    logic [1:0] prev_owner = '0;
    logic       prev_rst   = 1'b0;
    logic [3:0] cur_g      = '0;
    logic [1:0] cur_o      = '0;
    int         cur_len    = 0;
    int         cur_gap    = 0;
    int         zero_cnt   = 0;

    always @(negedge clk) begin
        exp_t e;
        chk("grant_onehot0", 32'(bus.grant == 4'b0 || $onehot(bus.grant)), 32'd1);
        chk("busy_vs_grant", 32'(bus.busy), 32'(bus.grant != 4'b0));
        if (bus.busy) chk("grant_at_owner", 32'(bus.grant[bus.owner]), 32'd1);
        if (bus.timeout) chk("timeout_after_release", 32'(prev_g != 4'b0), 32'd1);
        if (!bus.busy && !prev_busy && rst_n && prev_rst)
            chk("owner_hold", 32'(bus.owner), 32'(prev_owner));

        if (bus.grant != 4'b0) begin
            if (prev_g == 4'b0) begin
                cur_g   = bus.grant;
                cur_o   = bus.owner;
                cur_len = 1;
                cur_gap = zero_cnt;
            end else begin
                cur_len++;
                if (bus.grant != cur_g) chk("grant_stable", 32'(bus.grant), 32'(cur_g));
            end
        end else begin
            zero_cnt = (prev_g != 4'b0) ? 1 : zero_cnt + 1;
            if (prev_g != 4'b0) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_tenure actual=%b required=none at %0t", cur_g, $time);
                end else begin
                    e = q.pop_front();
                    chk("tenure_grant", 32'(cur_g), 32'(e.grant));
                    chk("tenure_owner", 32'(cur_o), 32'(e.owner));
                    chk("tenure_len", 32'(cur_len), 32'(e.len));
                    chk("tenure_timeout", 32'(bus.timeout), 32'(e.tmo));
                    if (e.gap >= 0) chk("tenure_gap", 32'(cur_gap), 32'(e.gap));
                end
            end
        end

        prev_g     = bus.grant;
        prev_busy  = bus.busy;
        prev_owner = bus.owner;
        prev_rst   = rst_n;
    end

    initial begin
        rst_n   = 1'b0;
        bus.req = 4'b0000;
        #2;
        chk("rst_grant", 32'(bus.grant), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_owner", 32'(bus.owner), 32'd0);
        chk("rst_timeout", 32'(bus.timeout), 32'd0);
        cyc(2);
        rst_n = 1'b1;
        cyc(1);

        // 1: single requester, three owned cycles
        push(4'b0001, 2'd0, 3, 1'b0, -1);
        bus.req = 4'b0001;
        cyc(3);
        bus.req = 4'b0000;
        cyc(5);

        // 2: all requesting from a fresh reset, every tenure forced out at the limit
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        push(4'b0001, 2'd0, 8, 1'b1, -1);
        push(4'b0010, 2'd1, 8, 1'b1, 3);
        push(4'b0100, 2'd2, 8, 1'b1, 3);
        push(4'b1000, 2'd3, 8, 1'b1, 3);
        push(4'b0001, 2'd0, 8, 1'b1, 3);
        bus.req = 4'b1111;
        cyc(53);
        bus.req = 4'b0000;
        cyc(5);

        // 3: owner 2, then 3 wins over 1 because last=2
        push(4'b0100, 2'd2, 3, 1'b0, -1);
        push(4'b1000, 2'd3, 4, 1'b0, 3);
        push(4'b0010, 2'd1, 2, 1'b0, 3);
        bus.req = 4'b0100;
        cyc(3);
        bus.req = 4'b1010;
        cyc(7);
        bus.req = 4'b0010;
        cyc(5);
        bus.req = 4'b0000;
        cyc(5);

        // 4: drop exactly on the limit edge is a normal release
        push(4'b0001, 2'd0, 8, 1'b0, -1);
        bus.req = 4'b0001;
        cyc(8);
        bus.req = 4'b0000;
        cyc(5);

        // 5: async reset mid-tenure, then pointer restarts at NREQ-1
        push(4'b0100, 2'd2, 1, 1'b0, -1);
        bus.req = 4'b0100;
        cyc(2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_grant", 32'(bus.grant), 32'd0);
        chk("async_rst_busy", 32'(bus.busy), 32'd0);
        chk("async_rst_owner", 32'(bus.owner), 32'd0);
        bus.req = 4'b1000;
        push(4'b1000, 2'd3, 2, 1'b0, -1);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_grant", 32'(bus.grant), 32'(4'b1000));
        cyc(1);
        bus.req = 4'b0000;

        // 6: one-cycle request inside turnaround is lost
        cyc(1);
        bus.req = 4'b0010;
        cyc(1);
        bus.req = 4'b0000;
        cyc(8);

        chk("final_grant_idle", 32'(bus.grant), 32'd0);
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
